// File: rtl/ar_mux_2to1_arb_pkg.sv
// Shared AR-channel types and widths.
// Also used by the R-path router for ID routing.
package ar_mux_2to1_arb_pkg;

  localparam int ID_W      = 4;
  localparam int ADDR_W    = 32;
  localparam int LEN_W     = 4;
  localparam int SIZE_W    = 3;
  localparam int BURST_W   = 2;
  localparam int ID_RT_BIT = 1;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } ar_beat_t;

  // Overwrite the routing bit with the master index.
  function automatic logic [ID_W-1:0] tag_id(
    input logic [ID_W-1:0] id,
    input logic            idx
  );
    logic [ID_W-1:0] t;
    t            = id;
    t[ID_RT_BIT] = idx;
    return t;
  endfunction

endpackage

// File: rtl/ar_mux_2to1_arb_rr_arb2.sv
// Two-way round-robin arbiter.
// Pointer moves past the granted master on advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // ptr=0: m1 wins a tie, ptr=1: m2 wins a tie
  logic ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11)
      grant = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= 1'b0;
    else if (advance)
      ptr <= grant[0];
  end

endmodule

// File: rtl/ar_mux_2to1_arb.sv
// Two-master AR mux with outstanding-burst limits,
// round-robin arbitration and a one-entry output register.
module ar_mux_2to1_arb
  import ar_mux_2to1_arb_pkg::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [ID_W-1:0]    arid_m1,
  input  logic [ADDR_W-1:0]  araddr_m1,
  input  logic [LEN_W-1:0]   arlen_m1,
  input  logic [SIZE_W-1:0]  arsize_m1,
  input  logic [BURST_W-1:0] arburst_m1,
  input  logic               arvalid_m1,
  output logic               arready_m1,
  input  logic [ID_W-1:0]    arid_m2,
  input  logic [ADDR_W-1:0]  araddr_m2,
  input  logic [LEN_W-1:0]   arlen_m2,
  input  logic [SIZE_W-1:0]  arsize_m2,
  input  logic [BURST_W-1:0] arburst_m2,
  input  logic               arvalid_m2,
  output logic               arready_m2,
  output logic [ID_W-1:0]    arid_s,
  output logic [ADDR_W-1:0]  araddr_s,
  output logic [LEN_W-1:0]   arlen_s,
  output logic [SIZE_W-1:0]  arsize_s,
  output logic [BURST_W-1:0] arburst_s,
  output logic               arvalid_s,
  input  logic               arready_s,
  input  logic [ID_W-1:0]    rid_s,
  input  logic               rlast_s,
  input  logic               rvalid_s,
  input  logic               rready_s
);

  localparam logic [2:0] LIMIT = 3'(MAX_OUTST);

  function automatic logic [2:0] next_cnt(
    input logic [2:0] c,
    input logic       inc,
    input logic       dec
  );
    case ({inc, dec})
      2'b10:   return c + 3'd1;
      2'b01:   return c - 3'd1;
      default: return c;
    endcase
  endfunction

  ar_beat_t   oreg;
  logic       oreg_v;
  ar_beat_t   beat_m1;
  ar_beat_t   beat_m2;
  logic [2:0] outst_m1;
  logic [2:0] outst_m2;
  logic [1:0] elig;
  logic [1:0] grant;
  logic       loadable;
  logic       accept;
  logic       r_done;
  logic       dec_m1;
  logic       dec_m2;

  assign beat_m1 = '{id:    tag_id(arid_m1, 1'b0),
                     addr:  araddr_m1,
                     len:   arlen_m1,
                     size:  arsize_m1,
                     burst: arburst_m1};
  assign beat_m2 = '{id:    tag_id(arid_m2, 1'b1),
                     addr:  araddr_m2,
                     len:   arlen_m2,
                     size:  arsize_m2,
                     burst: arburst_m2};

  assign elig[0]  = arvalid_m1 & (outst_m1 < LIMIT);
  assign elig[1]  = arvalid_m2 & (outst_m2 < LIMIT);
  assign loadable = ~oreg_v | arready_s;

  assign arready_m1 = loadable & grant[0] & ~areset;
  assign arready_m2 = loadable & grant[1] & ~areset;
  assign accept     = arready_m1 | arready_m2;

  rr_arb2 u_arb (
    .clk     (aclk),
    .rst     (areset),
    .req     (elig),
    .advance (accept),
    .grant   (grant)
  );

  // Burst completion is routed back to its master by one ID bit.
  assign r_done = rvalid_s & rready_s & rlast_s;
  assign dec_m1 = r_done & ~rid_s[ID_RT_BIT] & (outst_m1 != 3'd0);
  assign dec_m2 = r_done &  rid_s[ID_RT_BIT] & (outst_m2 != 3'd0);

  always_ff @(posedge aclk) begin
    if (areset) begin
      outst_m1 <= 3'd0;
      outst_m2 <= 3'd0;
    end else begin
      outst_m1 <= next_cnt(outst_m1, arready_m1, dec_m1);
      outst_m2 <= next_cnt(outst_m2, arready_m2, dec_m2);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      oreg   <= '0;
      oreg_v <= 1'b0;
    end else if (loadable) begin
      oreg_v <= accept;
      if (accept)
        oreg <= grant[1] ? beat_m2 : beat_m1;
    end
  end

  assign arvalid_s = oreg_v;
  assign arid_s    = oreg.id;
  assign araddr_s  = oreg.addr;
  assign arlen_s   = oreg.len;
  assign arsize_s  = oreg.size;
  assign arburst_s = oreg.burst;

endmodule

// File: tb/tb_ar_mux_2to1_arb.sv
// Directed bench for ar_mux_2to1_arb with a slave-side
// scoreboard fed by the stimulus and drained by a monitor.
module tb_ar_mux_2to1_arb;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  arid_m1, arid_m2, arid_s, rid_s;
  logic [31:0] araddr_m1, araddr_m2, araddr_s;
  logic [3:0]  arlen_m1, arlen_m2, arlen_s;
  logic [2:0]  arsize_m1, arsize_m2, arsize_s;
  logic [1:0]  arburst_m1, arburst_m2, arburst_s;
  logic        arvalid_m1, arvalid_m2, arready_m1, arready_m2;
  logic        arvalid_s, arready_s;
  logic        rlast_s, rvalid_s, rready_s;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 aclk = ~aclk;

  ar_mux_2to1_arb #(.MAX_OUTST(4)) dut (
    .aclk(aclk), .areset(areset),
    .arid_m1(arid_m1), .araddr_m1(araddr_m1),
    .arlen_m1(arlen_m1), .arsize_m1(arsize_m1),
    .arburst_m1(arburst_m1), .arvalid_m1(arvalid_m1),
    .arready_m1(arready_m1),
    .arid_m2(arid_m2), .araddr_m2(araddr_m2),
    .arlen_m2(arlen_m2), .arsize_m2(arsize_m2),
    .arburst_m2(arburst_m2), .arvalid_m2(arvalid_m2),
    .arready_m2(arready_m2),
    .arid_s(arid_s), .araddr_s(araddr_s),
    .arlen_s(arlen_s), .arsize_s(arsize_s),
    .arburst_s(arburst_s), .arvalid_s(arvalid_s),
    .arready_s(arready_s),
    .rid_s(rid_s), .rlast_s(rlast_s),
    .rvalid_s(rvalid_s), .rready_s(rready_s)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] id,
                      input logic [31:0] addr);
    exp_t e;
    e.id   = id;
    e.addr = addr;
    sb.push_back(e);
  endtask

  // Monitor: every slave-side handshake pops one entry.
  always @(negedge aclk) begin
    exp_t e;
    if (!areset && arvalid_s && arready_s) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexp: got id %0h addr %0h want none",
                 arid_s, araddr_s);
      end else begin
        e = sb.pop_front();
        chk("sb_arid", {28'd0, arid_s}, {28'd0, e.id});
        chk("sb_addr", araddr_s, e.addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic m1(input logic v, input logic [3:0] id,
                    input logic [31:0] a);
    arvalid_m1 = v; arid_m1 = id; araddr_m1 = a;
    arlen_m1 = 4'd3; arsize_m1 = 3'd2; arburst_m1 = 2'd1;
  endtask

  task automatic m2(input logic v, input logic [3:0] id,
                    input logic [31:0] a);
    arvalid_m2 = v; arid_m2 = id; araddr_m2 = a;
    arlen_m2 = 4'd7; arsize_m2 = 3'd3; arburst_m2 = 2'd2;
  endtask

  task automatic rbeat(input logic v, input logic [3:0] id);
    rvalid_s = v; rready_s = v; rlast_s = v; rid_s = id;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    m1(1'b1, 4'h1, 32'h0);
    m2(1'b1, 4'h1, 32'h0);
    @(negedge aclk);
    chk("rst_rdy_m1", {31'd0, arready_m1}, 0);
    chk("rst_rdy_m2", {31'd0, arready_m2}, 0);
    step();
    areset = 1'b0;
    m1(1'b0, 4'h0, 32'h0);
    m2(1'b0, 4'h0, 32'h0);
    sb.delete();
    @(negedge aclk);
    chk("rst_vs", {31'd0, arvalid_s}, 0);
    chk("rst_id", {28'd0, arid_s}, 0);
    chk("rst_addr", araddr_s, 0);
    step();
  endtask

  initial begin
    areset = 1'b1;
    arready_s = 1'b1;
    m1(1'b0, 4'h0, 32'h0);
    m2(1'b0, 4'h0, 32'h0);
    rbeat(1'b0, 4'h0);
    repeat (2) step();
    do_reset();

    // single m1 request, ID bit1 cleared
    m1(1'b1, 4'hF, 32'h1000);
    @(negedge aclk);
    chk("single_rdy", {31'd0, arready_m1}, 1);
    chk("single_vs_n", {31'd0, arvalid_s}, 0);
    push(4'hD, 32'h1000);
    step();
    m1(1'b0, 4'h0, 32'h0);
    @(negedge aclk);
    chk("single_vs_n1", {31'd0, arvalid_s}, 1);
    chk("single_id", {28'd0, arid_s}, 32'hD);
    chk("single_len", {28'd0, arlen_s}, 3);
    step();
    @(negedge aclk);
    chk("single_idle", {31'd0, arvalid_s}, 0);
    step();
    do_reset();

    // contention alternates m1,m2,m1,m2
    m1(1'b1, 4'h3, 32'h2000);
    m2(1'b1, 4'h5, 32'h3000);
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      chk("cont_m1", {31'd0, arready_m1}, (i % 2 == 0) ? 1 : 0);
      chk("cont_m2", {31'd0, arready_m2}, (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 0) push(4'h1, 32'h2000);
      else            push(4'h7, 32'h3000);
      step();
    end
    m1(1'b0, 4'h0, 32'h0);
    m2(1'b0, 4'h0, 32'h0);
    repeat (2) step();

    // backpressure: pointer now favours m1
    arready_s = 1'b0;
    m1(1'b1, 4'h0, 32'h4000);
    @(negedge aclk);
    chk("bp_acc", {31'd0, arready_m1}, 1);
    push(4'h0, 32'h4000);
    step();
    m1(1'b1, 4'h0, 32'h4100);
    m2(1'b1, 4'h2, 32'h5000);
    repeat (5) begin
      @(negedge aclk);
      chk("bp_m1", {31'd0, arready_m1}, 0);
      chk("bp_m2", {31'd0, arready_m2}, 0);
      chk("bp_vs", {31'd0, arvalid_s}, 1);
      chk("bp_addr", araddr_s, 32'h4000);
      step();
    end
    arready_s = 1'b1;
    @(negedge aclk);
    chk("bp_drain_m2", {31'd0, arready_m2}, 1);
    chk("bp_drain_m1", {31'd0, arready_m1}, 0);
    push(4'h2, 32'h5000);
    step();
    m2(1'b0, 4'h0, 32'h0);
    @(negedge aclk);
    chk("bp_next_m1", {31'd0, arready_m1}, 1);
    push(4'h0, 32'h4100);
    step();
    m1(1'b0, 4'h0, 32'h0);
    repeat (2) step();
    do_reset();

    // m1 limit, m2 bypass, release by rlast
    m1(1'b1, 4'h1, 32'h6000);
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      chk("lim_acc", {31'd0, arready_m1}, 1);
      push(4'h1, 32'h6000);
      step();
    end
    m2(1'b1, 4'h0, 32'h7000);
    @(negedge aclk);
    chk("lim_blk", {31'd0, arready_m1}, 0);
    chk("lim_m2", {31'd0, arready_m2}, 1);
    push(4'h2, 32'h7000);
    step();
    m2(1'b0, 4'h0, 32'h0);
    rbeat(1'b1, 4'h0);
    @(negedge aclk);
    chk("lim_still", {31'd0, arready_m1}, 0);
    step();
    rbeat(1'b0, 4'h0);
    @(negedge aclk);
    chk("lim_free", {31'd0, arready_m1}, 1);
    push(4'h1, 32'h6000);
    step();
    m1(1'b0, 4'h0, 32'h0);
    repeat (2) step();
    do_reset();

    // m2 accept and completion in the same cycle
    m2(1'b1, 4'h8, 32'h8000);
    for (int i = 0; i < 6; i++) begin
      rbeat(i == 2, 4'h2);
      @(negedge aclk);
      chk("sim_m2", {31'd0, arready_m2}, (i < 5) ? 1 : 0);
      if (i < 5) push(4'hA, 32'h8000);
      step();
    end
    m2(1'b0, 4'h0, 32'h0);
    rbeat(1'b0, 4'h0);
    repeat (2) step();

    // reset while the output register is full
    arready_s = 1'b0;
    m1(1'b1, 4'h4, 32'h9000);
    @(negedge aclk);
    chk("rf_acc", {31'd0, arready_m1}, 1);
    push(4'h4, 32'h9000);
    step();
    m1(1'b0, 4'h0, 32'h0);
    @(negedge aclk);
    chk("rf_full", {31'd0, arvalid_s}, 1);
    step();
    do_reset();
    arready_s = 1'b1;
    m1(1'b1, 4'h3, 32'hA000);
    m2(1'b1, 4'h5, 32'hB000);
    @(negedge aclk);
    chk("rf_m1", {31'd0, arready_m1}, 1);
    push(4'h1, 32'hA000);
    step();
    @(negedge aclk);
    chk("rf_m2", {31'd0, arready_m2}, 1);
    push(4'h7, 32'hB000);
    step();
    m1(1'b0, 4'h0, 32'h0);
    m2(1'b0, 4'h0, 32'h0);
    repeat (3) step();
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ar_mux_2to1_arb.md
AR_MUX_2TO1_ARB -- requirements
Module: ar_mux_2to1_arb

Interface
REQ-001 Parameter MAX_OUTST, default 4: per-master limit on outstanding read bursts (1..7).
REQ-002 aclk  in  1  sole clock; all state updates on rising edge.
REQ-003 areset  in  1  synchronous, active-high reset, sampled on the aclk rising edge.
REQ-004 arid_m1/arid_m2  in  4  master read ID.
REQ-005 araddr_m1/araddr_m2  in  32  read address.
REQ-006 arlen_m1/arlen_m2  in  4  burst length-1.
REQ-007 arsize_m1/arsize_m2  in  3  beat size.
REQ-008 arburst_m1/arburst_m2  in  2  burst type.
REQ-009 arvalid_m1/arvalid_m2  in  1  request valid.
REQ-010 arready_m1/arready_m2  out  1  request accepted.
REQ-011 arid_s, araddr_s, arlen_s, arsize_s, arburst_s  out  4/32/4/3/2  registered slave-side request.
REQ-012 arvalid_s  out  1; arready_s  in  1  slave AR handshake.
REQ-013 rid_s  in  4; rlast_s, rvalid_s, rready_s  in  1  R-channel monitor taps, used only for outstanding tracking.

Function
REQ-014 One-entry output register (OREG) holding a full AR beat plus valid flag; arvalid_s = OREG valid.
REQ-015 OREG is loadable in a cycle when OREG is empty, or full with arvalid_s & arready_s (drain); back-to-back transfers at one per cycle.
REQ-016 Eligible(mX) = arvalid_mX & (outst_mX < MAX_OUTST).
REQ-017 Grant is combinational in the loadable cycle: one eligible master -> that master; both eligible -> master indicated by the round-robin pointer.
REQ-018 arready_mX = loadable & grant_mX; at most one of arready_m1/arready_m2 high per cycle.
REQ-019 On accept in cycle N, OREG loads at edge end of N; arvalid_s high from cycle N+1 (latency 1).
REQ-020 ID tagging: arid_s = {arid_mX[3:2], idx, arid_mX[0]}, idx=0 for m1, 1 for m2; all other fields pass unchanged.
REQ-021 Round-robin pointer toggles to the non-granted master after each accept; unchanged when no accept.
REQ-022 OREG contents and arvalid_s remain stable while arvalid_s & !arready_s.
REQ-023 outst_mX (3-bit): +1 on accept of mX; -1 on rvalid_s & rready_s & rlast_s & (rid_s[1]==idx); both same cycle -> unchanged.
REQ-024 Decrement at outst_mX==0 is ignored (no underflow); increment cannot occur at MAX_OUTST by REQ-016.
REQ-025 Master at limit is skipped; the other master is granted regardless of pointer.
REQ-026 arvalid_mX deasserted without arready_mX: no state change.

Reset
REQ-027 areset high: OREG valid=0, all OREG fields=0, arvalid_s=0, arready_m1/m2=0, outst_m1=outst_m2=0, pointer=m1.
REQ-028 areset mid-transfer discards OREG content and counters; the first grant after release follows REQ-017 with pointer=m1.
REQ-029 arready_mX forced 0 while areset is high.

Structure
REQ-030 Shared package holds ID_W=4, ADDR_W=32, LEN_W=4, the ID routing bit index (1), and the AR beat struct/field widths, for reuse by the R-path router.
REQ-031 One sub-module rr_arb2: inputs req[1:0], advance; output grant[1:0]; owns the pointer.

Verification
REQ-032 Single: m1 arvalid, araddr=0x1000, arid=0xF, arready_s=1 -> arready_m1 cycle N, arvalid_s N+1, arid_s=0xD, araddr_s=0x1000.
REQ-033 Contention: both valid continuously, arready_s=1 -> grants m1,m2,m1,m2 on consecutive cycles; arid_s[1] toggles 0,1,0,1.
REQ-034 Backpressure: arready_s=0 for 5 cycles with OREG full -> arready_m1/m2 low, arvalid_s and payload stable; first arready_s=1 -> drain and new load same cycle.
REQ-035 Limit: 4 accepts from m1 with no R beats -> m1 blocked, m2 granted; one rlast beat rid_s=0x0 -> m1 grantable next cycle.
REQ-036 Simultaneous accept m2 and rlast with rid_s=0x2 -> outst_m2 unchanged.
REQ-037 areset asserted with OREG full -> next cycle arvalid_s=0, counters 0, next contention grants m1.
